ex_mem_pipe: RTL and testbench
==============================

// Module: ex_mem_pipe
// PURPOSE
// - Parametrised EX->MEM pipeline stage with a valid/ready handshake, 2-entry skid buffer and flush.
// - Replaces the fixed always-load EX/MEM register. Lets MEM stall without a combinational
//   ready path back into EX, and lets the branch/hazard unit squash in-flight ops.
// PARAMETERS
// - WordSize    32  width of alu_out / mem_data paths
// - RegIdxWidth 5   width of destination register index
// - CntWidth    16  width of stall counter (EXMEM_PERF_EN only)
// PORTS
// - clk              in   1            rising-edge clock
// - rst              in   1            reset: asynchronous, active-high
// - flush            in   1            synchronous squash of all held entries
// - in_valid         in   1            EX presents an op
// - in_ready         out  1            stage accepts an op this cycle
// - rdn_in           in   RegIdxWidth  destination register index
// - alu_out_in       in   WordSize     ALU result / effective address
// - rs2d             in   WordSize     store data
// - branch_taken_in  in   1            branch resolved taken
// - mem_we_in        in   1            op is a store
// - out_valid        out  1            MEM-side entry valid
// - out_ready        in   1            MEM consumes the entry this cycle
// - rdn              out  RegIdxWidth  head entry fields
// - alu_out          out  WordSize
// - mem_data         out  WordSize
// - branch_taken     out  1
// - mem_we           out  1
// - occupancy        out  2            entries held: 0, 1 or 2
// - stall_cnt        out  CntWidth     saturating stall count (EXMEM_PERF_EN only)
// BEHAVIOUR
// - Storage: head register (drives outputs) plus skid register. State EMPTY/ONE/TWO = occupancy.
// - Transfer rules:
//   - acc = in_valid & in_ready
//   - pop = out_valid & out_ready
// - in_ready = !skid_valid & !rst. Depends only on registered state; no comb path from out_ready.
// - out_valid = head_valid, registered.
// - EMPTY:
//   - acc  -> ONE, head <= inputs.
// - ONE:
//   - acc & pop -> ONE, head <= inputs.
//   - acc only  -> TWO, skid <= inputs.
//   - pop only  -> EMPTY.
//   - neither   -> hold.
// - TWO:
//   - in_ready = 0.
//   - pop -> ONE, head <= skid, skid_valid <= 0.
//   - else hold.
// - Latency: an op accepted into EMPTY appears on the outputs 1 cycle later.
//   Full throughput (1 op/cycle) while out_ready stays high.
// - Order: strict FIFO; the skid entry never overtakes head.
// - Flush: highest priority. Next state EMPTY and both valids cleared.
//   - An input offered the same cycle is dropped, even if in_ready = 1.
//   - A pop in the same cycle still counts as consumed by MEM.
//   - Data registers hold their values.
// - Data outputs while out_valid = 0: hold last value. Not required to be zero, except after reset.
// - Reset (async assert, sync release):
//   - out_valid, occupancy, rdn, alu_out, mem_data, branch_taken, mem_we, stall_cnt = 0.
//   - Skid contents = 0.
//   - in_ready = 0 while rst is high; 1 in the first cycle after release.
//   - Reset mid-transfer discards all entries.
// - occupancy never exceeds 2.
//   - acc in TWO is impossible by construction.
//   - A bench-forced in_valid in TWO must be ignored.
// CONFIGURATION
// - EXMEM_PERF_EN defined:
//   - stall_cnt increments each cycle with out_valid & !out_ready.
//   - Saturates at all-ones; cleared only by rst, not by flush.
// - EXMEM_PERF_EN undefined: stall_cnt port and its logic are absent. All other behaviour is identical.
// TESTING
// - Reset: hold rst 3 cycles mid-stream -> all outputs 0, in_ready = 0; after release in_ready = 1, occupancy = 0.
// - Streaming: out_ready = 1, push rdn 1..8 with alu_out = 0x100+i
//   -> each appears 1 cycle after accept, in order, no bubbles.
// - Backpressure: out_ready = 0, push A(rdn = 3), B(rdn = 4)
//   -> occupancy = 2, in_ready = 0, outputs show A;
//   -> raise out_ready: A, then B, then out_valid = 0.
// - Flush: occupancy = 2, assert flush together with in_valid = 1
//   -> next cycle occupancy = 0, out_valid = 0, the offered op is never output.
// - Store path: rs2d = 0xDEADBEEF, mem_we_in = 1, branch_taken_in = 1
//   -> mem_data = 0xDEADBEEF, mem_we = 1, branch_taken = 1 at the head.
// - Perf (EXMEM_PERF_EN, CntWidth = 4): out_valid = 1, out_ready = 0 for 20 cycles
//   -> stall_cnt = 15, holds; flush does not clear it; rst does.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// ============================================================================
// Module      : ex_mem_pipe
// Description : EX->MEM pipeline stage with valid/ready handshake, 2-entry
//               skid buffer and synchronous flush. Define EXMEM_PERF_EN to
//               add the saturating MEM-stall counter (stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_pipe #(
    parameter int WordSize    = 32,
    parameter int RegIdxWidth = 5
`ifdef EXMEM_PERF_EN
    ,
    parameter int CntWidth    = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RegIdxWidth-1:0] rdn_in,
    input  logic [WordSize-1:0]    alu_out_in,
    input  logic [WordSize-1:0]    rs2d,
    input  logic                   branch_taken_in,
    input  logic                   mem_we_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RegIdxWidth-1:0] rdn,
    output logic [WordSize-1:0]    alu_out,
    output logic [WordSize-1:0]    mem_data,
    output logic                   branch_taken,
    output logic                   mem_we,
    output logic [1:0]             occupancy
`ifdef EXMEM_PERF_EN
    ,
    output logic [CntWidth-1:0]    stall_cnt
`endif
);

    localparam int c_ENTRY_W = RegIdxWidth + 2 * WordSize + 2;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_ENTRY_W-1:0] r_head;
    logic [c_ENTRY_W-1:0] r_skid;
    logic [c_ENTRY_W-1:0] w_in_entry;
    logic                 w_acc;
    logic                 w_pop;
    logic                 w_ld_head_in;
    logic                 w_ld_head_skid;
    logic                 w_ld_skid;

    assign w_in_entry = {rdn_in, alu_out_in, rs2d, branch_taken_in, mem_we_in};

    // Ready comes only from registered state, so MEM stalls never ripple into EX.
    assign in_ready  = (r_state != S_TWO) & ~rst;
    assign out_valid = (r_state != S_EMPTY);
    assign occupancy = r_state;
    assign w_acc     = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign {rdn, alu_out, mem_data, branch_taken, mem_we} = r_head;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_head_in   = 1'b0;
        w_ld_head_skid = 1'b0;
        w_ld_skid      = 1'b0;
        unique case (r_state)
            S_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt  = S_ONE;
                    w_ld_head_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_acc && w_pop) begin
                    w_ld_head_in = 1'b1;
                end else if (w_acc) begin
                    w_state_nxt = S_TWO;
                    w_ld_skid   = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_pop) begin
                    w_state_nxt    = S_ONE;
                    w_ld_head_skid = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Flush drops everything, including an op offered this cycle; data regs keep their values.
        if (flush) begin
            w_state_nxt    = S_EMPTY;
            w_ld_head_in   = 1'b0;
            w_ld_head_skid = 1'b0;
            w_ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_head_in) begin
                r_head <= w_in_entry;
            end else if (w_ld_head_skid) begin
                r_head <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

`ifdef EXMEM_PERF_EN
    logic [CntWidth-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + {{(CntWidth-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
// ============================================================================
// Module      : tb_ex_mem_pipe
// Description : Directed, table-driven bench for ex_mem_pipe (EXMEM_PERF_EN
//               optional, exercised with CntWidth = 4 when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rdn_in;
    logic [31:0] alu_out_in;
    logic [31:0] rs2d;
    logic        branch_taken_in;
    logic        mem_we_in;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rdn;
    logic [31:0] alu_out;
    logic [31:0] mem_data;
    logic        branch_taken;
    logic        mem_we;
    logic [1:0]  occupancy;
`ifdef EXMEM_PERF_EN
    logic [3:0]  stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    ex_mem_pipe #(
        .WordSize    (32),
        .RegIdxWidth (5)
`ifdef EXMEM_PERF_EN
        ,
        .CntWidth    (4)
`endif
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .rdn_in          (rdn_in),
        .alu_out_in      (alu_out_in),
        .rs2d            (rs2d),
        .branch_taken_in (branch_taken_in),
        .mem_we_in       (mem_we_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .rdn             (rdn),
        .alu_out         (alu_out),
        .mem_data        (mem_data),
        .branch_taken    (branch_taken),
        .mem_we          (mem_we),
        .occupancy       (occupancy)
`ifdef EXMEM_PERF_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl, iv, ordy;
        logic [4:0]  rdn;
        logic [31:0] alu, rs2;
        logic        bt, we;
        logic        e_ov, e_ir;
        logic [1:0]  e_occ;
        logic [4:0]  e_rdn;
        logic [31:0] e_alu, e_md;
        logic        e_bt, e_we;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int fl, input int iv, input int ordy, input int r,
                       input logic [31:0] alu, input logic [31:0] rs2, input int bt, input int we,
                       input int e_ov, input int e_ir, input int e_occ, input int e_rdn,
                       input logic [31:0] e_alu, input logic [31:0] e_md, input int e_bt, input int e_we);
        vec_t v;
        v.fl = 1'(fl);     v.iv = 1'(iv);      v.ordy = 1'(ordy);
        v.rdn = 5'(r);     v.alu = alu;        v.rs2 = rs2;
        v.bt = 1'(bt);     v.we = 1'(we);
        v.e_ov = 1'(e_ov); v.e_ir = 1'(e_ir);  v.e_occ = 2'(e_occ);
        v.e_rdn = 5'(e_rdn); v.e_alu = e_alu;  v.e_md = e_md;
        v.e_bt = 1'(e_bt); v.e_we = 1'(e_we);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy, input logic [4:0] r,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic bt, input logic we);
        flush = fl; in_valid = iv; out_ready = ordy; rdn_in = r;
        alu_out_in = alu; rs2d = rs2; branch_taken_in = bt; mem_we_in = we;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Expected outputs are sampled just after the edge that consumes each row's inputs.
        //   fl iv or rdn alu       rs2           bt we | ov ir occ rdn alu      md            bt we
        add(0, 1, 0, 3, 32'hA0,  32'h11,       0, 0,   1, 1, 1, 3, 32'hA0,  32'h11,       0, 0);
        add(0, 1, 0, 4, 32'hB0,  32'h22,       0, 0,   1, 0, 2, 3, 32'hA0,  32'h11,       0, 0);
        add(0, 1, 0, 5, 32'hC0,  32'h33,       0, 0,   1, 0, 2, 3, 32'hA0,  32'h11,       0, 0);
        add(0, 0, 1, 0, 32'h0,   32'h0,        0, 0,   1, 1, 1, 4, 32'hB0,  32'h22,       0, 0);
        add(0, 0, 1, 0, 32'h0,   32'h0,        0, 0,   0, 1, 0, 4, 32'hB0,  32'h22,       0, 0);
        add(0, 1, 0, 7, 32'h44,  32'hDEADBEEF, 1, 1,   1, 1, 1, 7, 32'h44,  32'hDEADBEEF, 1, 1);
        add(0, 1, 0, 8, 32'h55,  32'h66,       0, 0,   1, 0, 2, 7, 32'h44,  32'hDEADBEEF, 1, 1);
        add(1, 1, 0, 9, 32'h99,  32'h77,       0, 1,   0, 1, 0, 7, 32'h44,  32'hDEADBEEF, 1, 1);
        add(0, 0, 1, 0, 32'h0,   32'h0,        0, 0,   0, 1, 0, 7, 32'h44,  32'hDEADBEEF, 1, 1);
        add(0, 1, 0, 10, 32'hAA, 32'h0,        0, 0,   1, 1, 1, 10, 32'hAA, 32'h0,        0, 0);
        add(1, 0, 1, 0, 32'h0,   32'h0,        0, 0,   0, 1, 0, 10, 32'hAA, 32'h0,        0, 0);
        add(0, 1, 1, 11, 32'hBB, 32'h1,        0, 0,   1, 1, 1, 11, 32'hBB, 32'h1,        0, 0);
        add(0, 1, 1, 12, 32'hCC, 32'h2,        1, 0,   1, 1, 1, 12, 32'hCC, 32'h2,        1, 0);
        add(0, 0, 1, 0, 32'h0,   32'h0,        0, 0,   0, 1, 0, 12, 32'hCC, 32'h2,        1, 0);

        // Power-on reset state.
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_rdn",       64'(rdn),       64'd0);
        chk("rst_alu_out",   64'(alu_out),   64'd0);
        chk("rst_mem_data",  64'(mem_data),  64'd0);
        chk("rst_bt_we",     64'({branch_taken, mem_we}), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready",  64'(in_ready),  64'd1);
        chk("rel_occupancy", 64'(occupancy), 64'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].rdn,
                  vecs[i].alu, vecs[i].rs2, vecs[i].bt, vecs[i].we);
            step();
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
            chk($sformatf("v%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].e_occ));
            chk($sformatf("v%0d_rdn", i),       64'(rdn),       64'(vecs[i].e_rdn));
            chk($sformatf("v%0d_alu_out", i),   64'(alu_out),   64'(vecs[i].e_alu));
            chk($sformatf("v%0d_mem_data", i),  64'(mem_data),  64'(vecs[i].e_md));
            chk($sformatf("v%0d_branch", i),    64'(branch_taken), 64'(vecs[i].e_bt));
            chk($sformatf("v%0d_mem_we", i),    64'(mem_we),    64'(vecs[i].e_we));
        end

        // Streaming at full throughput: each op shows up one edge after it is accepted.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 1'b1, 5'(i), 32'h100 + 32'(i), 32'd0, 1'b0, 1'b0);
            step();
            chk($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("stream%0d_rdn", i),   64'(rdn),       64'(i));
            chk($sformatf("stream%0d_alu", i),   64'(alu_out),   64'h100 + 64'(i));
            chk($sformatf("stream%0d_ready", i), 64'(in_ready),  64'd1);
        end
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("stream_drain_valid", 64'(out_valid), 64'd0);
        chk("stream_drain_occ",   64'(occupancy), 64'd0);

        // Reset while two entries are held.
        drive(1'b0, 1'b1, 1'b0, 5'd20, 32'h200, 32'h1, 1'b1, 1'b1);
        step();
        drive(1'b0, 1'b1, 1'b0, 5'd21, 32'h210, 32'h2, 1'b0, 1'b0);
        step();
        chk("pre_rst_occ", 64'(occupancy), 64'd2);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_occ",   64'(occupancy), 64'd0);
        chk("mid_rst_data",  64'({rdn, branch_taken, mem_we}), 64'd0);
        chk("mid_rst_alu",   64'(alu_out),   64'd0);
        chk("mid_rst_md",    64'(mem_data),  64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mid_rst_ready%0d", i), 64'(in_ready), 64'd0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(in_ready),  64'd1);
        chk("post_rst_occ",   64'(occupancy), 64'd0);
        step();
        chk("post_rst_valid", 64'(out_valid), 64'd0);

`ifdef EXMEM_PERF_EN
        chk("perf_reset_zero", 64'(stall_cnt), 64'd0);
        drive(1'b0, 1'b1, 1'b0, 5'd1, 32'h1, 32'h0, 1'b0, 1'b0);
        step();
        chk("perf_first_zero", 64'(stall_cnt), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk("perf_count5", 64'(stall_cnt), 64'd5);
        for (int i = 0; i < 15; i++) step();
        chk("perf_saturate", 64'(stall_cnt), 64'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("perf_flush_keep", 64'(stall_cnt), 64'd15);
        chk("perf_flush_empty", 64'(out_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("perf_rst_clear", 64'(stall_cnt), 64'd0);
        rst = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
